port_array_rr_arbiter: RTL and testbench

- Round-robin arbiter and merge point for a packed port array of val/rdy message streams.
- Shares a single output channel among nports requesters.
- Registers the winning message in a one-entry pipelined output buffer.
- Sits downstream of per-port pass-through or queue stages, and feeds one shared consumer (memory port, network injection, etc.).

---
 rtl/port_array_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_port_array_rr_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/port_array_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : port_array_rr_arbiter
// Brief    : Round-robin merge of a packed val/rdy port array into one
//            pipelined, one-entry output buffer. Optional packet locking is
//            enabled by defining PORT_ARRAY_RR_ARBITER_PKT_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module port_array_rr_arbiter #(
  parameter int NPORTS = 2,
  parameter int NBITS  = 32,
  localparam int PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NPORTS-1:0]             in_val,
  output logic [NPORTS-1:0]             in_rdy,
  input  logic [NPORTS-1:0][NBITS-1:0]  in_msg,
`ifdef PORT_ARRAY_RR_ARBITER_PKT_LOCK_EN
  input  logic [NPORTS-1:0]             in_last,
`endif
  output logic                          out_val,
  input  logic                          out_rdy,
  output logic [NBITS-1:0]              out_msg,
  output logic [PW-1:0]                 out_src
);

  localparam logic [PW:0]   c_nports = (PW+1)'(NPORTS);
  localparam logic [PW-1:0] c_last   = PW'(NPORTS - 1);
  localparam logic [PW-1:0] c_one    = PW'(1);

  logic                 r_out_val;
  logic [NBITS-1:0]     r_out_msg;
  logic [PW-1:0]        r_out_src;
  logic [PW-1:0]        r_ptr;

  logic                 w_acc;
  logic                 w_any;
  logic                 w_grant_val;
  logic                 w_xfer;
  logic                 w_last;
  logic [2*NPORTS-1:0]  w_dbl_val;
  logic [NPORTS-1:0]    w_rot_val;
  logic [PW-1:0]        w_off;
  logic [PW:0]          w_sum;
  logic [PW-1:0]        w_rr_grant;
  logic [PW-1:0]        w_grant;
  logic [PW-1:0]        w_ptr_nxt;

  // Pipelined buffer: it may refill in the same cycle it drains.
  assign w_acc = !r_out_val || out_rdy;

  // Rotate so that bit 0 is the port currently holding priority.
  assign w_dbl_val = {in_val, in_val} >> r_ptr;
  assign w_rot_val = w_dbl_val[NPORTS-1:0];
  assign w_any     = |in_val;

  always_comb begin
    w_off = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      if (w_rot_val[k]) begin
        w_off = PW'(k);
      end
    end
  end

  assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_rr_grant = (w_sum >= c_nports) ? PW'(w_sum - c_nports) : PW'(w_sum);

`ifdef PORT_ARRAY_RR_ARBITER_PKT_LOCK_EN
  logic          r_lock;
  logic [PW-1:0] r_lock_src;

  // A locked packet owns the output until its last beat.
  assign w_grant     = r_lock ? r_lock_src : w_rr_grant;
  assign w_grant_val = r_lock ? in_val[r_lock_src] : w_any;
  assign w_last      = in_last[w_grant];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock     <= 1'b0;
      r_lock_src <= '0;
    end else if (w_xfer) begin
      r_lock     <= !w_last;
      r_lock_src <= w_grant;
    end
  end
`else
  assign w_grant     = w_rr_grant;
  assign w_grant_val = w_any;
  assign w_last      = 1'b1;
`endif

  assign w_xfer    = w_grant_val && w_acc && !reset;
  assign w_ptr_nxt = (w_grant == c_last) ? '0 : w_grant + c_one;

  always_comb begin
    in_rdy = '0;
    if (w_xfer) begin
      in_rdy[w_grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_val <= 1'b0;
      r_out_msg <= '0;
      r_out_src <= '0;
      r_ptr     <= '0;
    end else begin
      if (w_xfer) begin
        r_out_val <= 1'b1;
        r_out_msg <= in_msg[w_grant];
        r_out_src <= w_grant;
        if (w_last) begin
          r_ptr <= w_ptr_nxt;
        end
      end else if (r_out_val && out_rdy) begin
        r_out_val <= 1'b0;
      end
    end
  end

  assign out_val = r_out_val;
  assign out_msg = r_out_msg;
  assign out_src = r_out_src;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(in_rdy));
      assert (r_ptr <= c_last);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_port_array_rr_arbiter.sv
`default_nettype none
// Scoreboarded bench for port_array_rr_arbiter (3 ports, exercises non-power-of-two wrap).
module tb_port_array_rr_arbiter;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        in_val;
  logic [N-1:0]        in_rdy;
  logic [N-1:0]        in_last;
  logic [N-1:0][W-1:0] in_msg;
  logic                out_val;
  logic                out_rdy;
  logic [W-1:0]        out_msg;
  logic [SW-1:0]       out_src;

  always #5 clk = ~clk;

  port_array_rr_arbiter #(.NPORTS(N), .NBITS(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
`ifdef PORT_ARRAY_RR_ARBITER_PKT_LOCK_EN
    .in_last (in_last),
`endif
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .out_src (out_src)
  );

  typedef struct {
    logic [W-1:0] msg;
    int           src;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model state, kept in spec terms.
  int   m_ptr  = 0;
  bit   m_bval = 1'b0;
  bit   m_lock = 1'b0;
  int   m_lsrc = 0;

  task automatic step(input logic [N-1:0] v, input bit ordy, input logic [N-1:0] last,
                      input bit rst, input bit seq_msg);
    int           g;
    int           idx;
    bit           acc;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] eff_last;
    @(negedge clk);
    cyc++;
    reset   = rst;
    in_val  = v;
    out_rdy = ordy;
    in_last = last;
    for (int i = 0; i < N; i++) begin
      in_msg[i] = seq_msg ? W'(32'hA0 + i) : W'($urandom);
    end
    #1;
`ifdef PORT_ARRAY_RR_ARBITER_PKT_LOCK_EN
    eff_last = last;
`else
    eff_last = '1;
`endif
    g = -1;
    if (m_lock) begin
      if (v[m_lsrc]) g = m_lsrc;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    acc     = !m_bval || ordy;
    exp_rdy = '0;
    if (!rst && g >= 0 && acc) exp_rdy[g] = 1'b1;
    checks++;
    if (in_rdy !== exp_rdy) begin
      errors++;
      $display("FAIL in_rdy cyc=%0d got=%b exp=%b", cyc, in_rdy, exp_rdy);
    end
    if (rst) begin
      q.delete();
      m_ptr  = 0;
      m_bval = 1'b0;
      m_lock = 1'b0;
      m_lsrc = 0;
    end else if (g >= 0 && acc) begin
      q.push_back('{in_msg[g], g, cyc});
      m_bval = 1'b1;
      if (eff_last[g]) begin
        m_lock = 1'b0;
        m_ptr  = (g + 1) % N;
      end else begin
        m_lock = 1'b1;
        m_lsrc = g;
      end
    end else if (m_bval && ordy) begin
      m_bval = 1'b0;
    end
  endtask

  // Monitor: compares the buffered output against the scoreboard queue.
  initial begin : monitor
    bit exp_v;
    forever begin
      @(negedge clk);
      #3;
      if (!reset) begin
        exp_v = (q.size() > 0) && (q[0].cyc < cyc);
        checks++;
        if (out_val !== exp_v) begin
          errors++;
          $display("FAIL out_val cyc=%0d got=%b exp=%b", cyc, out_val, exp_v);
        end
        if (exp_v && out_val === 1'b1) begin
          checks++;
          if (out_msg !== q[0].msg || out_src !== SW'(q[0].src)) begin
            errors++;
            $display("FAIL out_data cyc=%0d got msg=%h src=%0d exp msg=%h src=%0d",
                     cyc, out_msg, out_src, q[0].msg, q[0].src);
          end
          if (out_rdy) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    in_val  = '1;
    out_rdy = 1'b0;
    in_last = '1;
    in_msg  = '0;

    // Reset with every requester active.
    step('1, 1'b1, '1, 1'b1, 1'b1);
    step('1, 1'b1, '1, 1'b1, 1'b1);
    checks++;
    if (out_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_val got=%b exp=0", out_val);
    end

    // Round robin with all ports requesting, then hold off the consumer.
    repeat (5) step('1, 1'b1, '1, 1'b0, 1'b1);
    repeat (3) step('1, 1'b0, '1, 1'b0, 1'b1);
    repeat (2) step('1, 1'b1, '1, 1'b0, 1'b1);

    // Sparse requests across the wrap point, then idle drain.
    step(3'b000, 1'b1, '1, 1'b0, 1'b1);
    step(3'b010, 1'b1, '1, 1'b0, 1'b1);
    step(3'b001, 1'b1, '1, 1'b0, 1'b1);
    step(3'b100, 1'b1, '1, 1'b0, 1'b1);
    repeat (3) step(3'b000, 1'b1, '1, 1'b0, 1'b1);

    // Multi-beat packet from port 1 competing with port 0.
    step(3'b011, 1'b1, 3'b101, 1'b0, 1'b0);
    step(3'b011, 1'b1, 3'b101, 1'b0, 1'b0);
    step(3'b011, 1'b1, 3'b111, 1'b0, 1'b0);
    step(3'b001, 1'b1, 3'b111, 1'b0, 1'b0);
    repeat (2) step(3'b000, 1'b1, '1, 1'b0, 1'b0);

    // Randomized traffic with occasional mid-run reset.
    repeat (3000) begin
      step(N'($urandom), ($urandom % 4) != 0, N'($urandom), ($urandom % 200) == 0, 1'b0);
    end

    repeat (3) step('0, 1'b1, '1, 1'b0, 1'b0);
    checks++;
    if (q.size() != 0 || out_val !== 1'b0) begin
      errors++;
      $display("FAIL drain pending=%0d out_val=%b exp pending=0 out_val=0", q.size(), out_val);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
